code_issue: RTL and testbench
=============================

Name: code_issue

Overview:
- Encoder/issuer for the datapath instruction word; the inverse of the datapath field decoder.
- Accepts instruction fields from the host/controller and packs them into a code word laid out as {op, param_a, param_b}, or as {op, cost_type} for cost ops.
- Buffers packed words in a small FIFO.
- Issues each word to the datapath over a valid/ready handshake, optionally repeated N times for loop-style execution.

Parameters:
- op_size, 4, width of opcode field.
- param_a_size, 4, width of act_type field (upper parameter field).
- param_b_size, 4, width of dense_type field (lower parameter field).
- depth, 4, FIFO entries; power of two, ≥2.
- repeat_width, 4, width of per-entry repeat count.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  host presents an instruction.
- in_ready  out  1  block can accept; equals !full.
- in_fmt  in  1  0 = split fields (act/dense), 1 = combined cost field.
- in_op  in  op_size  opcode.
- in_act_type  in  param_a_size  used when in_fmt=0.
- in_dense_type  in  param_b_size  used when in_fmt=0.
- in_cost_type  in  param_a_size+param_b_size  used when in_fmt=1.
- in_repeat  in  repeat_width  extra issues; entry is issued in_repeat+1 times.
- flush  in  1  synchronous clear of FIFO and repeat state.
- out_valid  out  1  code is valid.
- out_ready  in  1  datapath accepts code.
- code  out  op_size+param_a_size+param_b_size  packed instruction.
- out_last  out  1  high with the final issue of the current entry.
- count  out  $clog2(depth)+1  occupied entries.

Behaviour:
- Reset (rst_n low, async): FIFO pointers and count = 0, rep_cnt = 0, out_valid = 0, out_last = 0, code = 0, in_ready = 1.
- Packing at push:
  - fmt=0: word = {in_op, in_act_type, in_dense_type}.
  - fmt=1: word = {in_op, in_cost_type}.
  - Unused inputs are ignored.
  - Stored word and in_repeat are written together.
- Push: occurs on a clk edge when in_valid && in_ready && !flush. The entry becomes visible at the head on the next cycle; push-to-out_valid latency is 1 cycle.
- Head presentation:
  - out_valid = (count != 0).
  - code = head word; code = 0 when empty.
  - out_last = out_valid && (rep_cnt == head_repeat).
- Issue:
  - Each out_valid && out_ready edge is one beat.
  - If rep_cnt < head_repeat: rep_cnt increments and the head stays.
  - Otherwise: pop head, rep_cnt = 0.
- Backpressure: while out_valid && !out_ready, code, out_last and rep_cnt hold stable.
- Simultaneous push and pop: both occur and count is unchanged.
- Full: in_ready = 0 while full, including a cycle where a pop occurs. There is no same-cycle bypass.
- Empty: no pop, rep_cnt holds 0, out_valid = 0.
- Pointers wrap modulo depth.
- Flush: takes priority over push and pop. The next cycle has count = 0, rep_cnt = 0, out_valid = 0, in_ready = 1. A flush in the middle of a repeat sequence abandons the remaining beats.
- Reset mid-operation: all state returns to reset values immediately; stored entries are lost.
- State machine, two states:
  - IDLE (count=0) → ISSUE on push.
  - ISSUE → IDLE when the last beat of the last entry pops with no concurrent push, or on flush.
  - rep_cnt is meaningful only in ISSUE.

Decomposition:
- Shared package code_pkg holds:
  - the field width constants op_size, param_a_size, param_b_size and the derived code width;
  - the fmt encoding constants FMT_SPLIT=0 and FMT_COST=1;
  - the opcode constants shared with the datapath decoder.
- One sub-module, code_fifo: a generic synchronous FIFO (width, depth) exposing full, empty, count, head data and push/pop.
- code_issue contains the packing logic, the repeat counter, the state machine and the flush handling.

Test Plan:
- Split push: fmt=0, op=4'h3, act=4'h2, dense=4'h5, repeat=0 with out_ready=1 → next cycle code=12'h325, out_valid=1, out_last=1; the following cycle out_valid=0.
- Cost push: fmt=1, op=4'h9, cost=8'hA7 → code=12'h9A7. Decoding it back gives act=4'hA and dense=4'h7.
- Repeat: one entry with repeat=2 and out_ready=1 → three beats of the same code, out_last only on beat 3, then the next entry.
- Full/backpressure: out_ready=0, push 4 entries → count=4, in_ready=0, and a 5th in_valid is not accepted. Then out_ready=1 → entries drain in order and in_ready rises after the first pop.
- Flush mid-repeat: entry with repeat=5 and flush asserted after 2 beats, with in_valid high on the same cycle → next cycle count=0, out_valid=0, and the pushed entry is dropped.
- Async reset: drop rst_n mid-drain between clock edges → outputs go to reset values immediately, and code=0 after release.

Source files
------------

// File: rtl/code_pkg.sv
// Shared definitions for the datapath instruction word.
// Holds the field widths, the packing format selector encoding, the opcode
// values shared with the datapath field decoder, and the issuer state type.
package code_pkg;

  localparam int op_size      = 4;
  localparam int param_a_size = 4;
  localparam int param_b_size = 4;
  localparam int code_size    = op_size + param_a_size + param_b_size;

  // Packing format selector carried on in_fmt.
  localparam logic FMT_SPLIT = 1'b0;
  localparam logic FMT_COST  = 1'b1;

  // Opcodes understood by the datapath decoder.
  localparam logic [op_size-1:0] OP_NOP   = 4'h0;
  localparam logic [op_size-1:0] OP_LOAD  = 4'h1;
  localparam logic [op_size-1:0] OP_STORE = 4'h2;
  localparam logic [op_size-1:0] OP_DENSE = 4'h3;
  localparam logic [op_size-1:0] OP_ACT   = 4'h4;
  localparam logic [op_size-1:0] OP_COST  = 4'h9;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } issue_state_t;

endpackage

// File: rtl/code_fifo.sv
// Generic synchronous FIFO.
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   flush           synchronous clear of pointers and count (wins over push/pop)
//   push, push_data write an entry (ignored while full)
//   pop             discard the head entry (ignored while empty)
//   head_data       entry at the head (don't-care while empty)
//   full, empty     occupancy flags
//   count           number of occupied entries
module code_fifo #(
  parameter int width = 8,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [width-1:0]         push_data,
  input  logic                     pop,
  output logic [width-1:0]         head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);

  localparam int ptr_w = $clog2(depth);
  localparam int cnt_w = ptr_w + 1;
  localparam logic [cnt_w-1:0] full_cnt = cnt_w'(depth);

  logic [width-1:0] mem [depth];
  logic [ptr_w-1:0] wr_ptr;
  logic [ptr_w-1:0] rd_ptr;
  logic [cnt_w-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign full      = (cnt == full_cnt);
  assign empty     = (cnt == '0);
  assign count     = cnt;
  assign head_data = mem[rd_ptr];

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Storage needs no reset; emptiness is tracked by cnt alone.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Depth is a power of two, so pointer wrap is plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/code_issue.sv
// Instruction word encoder/issuer: the inverse of the datapath field decoder.
// Packs host-supplied fields into {op, act, dense} or {op, cost}, buffers the
// words with a per-entry repeat count, and issues each entry repeat+1 times
// over a valid/ready handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | FIFO empty, nothing presented to the datapath
// ST_ISSUE | head entry presented; rep_cnt counts beats already issued
//
// Ports:
//   clk, rst_n                          clock, async active-low reset
//   in_valid / in_ready                 host handshake (in_ready = !full)
//   in_fmt                              FMT_SPLIT or FMT_COST packing
//   in_op, in_act_type, in_dense_type   split-format fields
//   in_cost_type                        combined cost field
//   in_repeat                           extra issues of this entry
//   flush                               drop all entries and repeat state
//   out_valid / out_ready               datapath handshake
//   code                                packed word, 0 when empty
//   out_last                            final beat of the head entry
//   count                               occupied FIFO entries
module code_issue
  import code_pkg::*;
#(
  parameter int depth        = 4,
  parameter int repeat_width = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_fmt,
  input  logic [op_size-1:0]                 in_op,
  input  logic [param_a_size-1:0]            in_act_type,
  input  logic [param_b_size-1:0]            in_dense_type,
  input  logic [param_a_size+param_b_size-1:0] in_cost_type,
  input  logic [repeat_width-1:0]            in_repeat,
  input  logic                               flush,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [code_size-1:0]               code,
  output logic                               out_last,
  output logic [$clog2(depth):0]             count
);

  localparam int entry_w = code_size + repeat_width;
  localparam int cnt_w   = $clog2(depth) + 1;

  logic [code_size-1:0]    word;
  logic [entry_w-1:0]      head_data;
  logic [code_size-1:0]    head_word;
  logic [repeat_width-1:0] head_repeat;
  logic [repeat_width-1:0] rep_cnt;
  logic [cnt_w-1:0]        fifo_count;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    push;
  logic                    beat;
  logic                    last_beat;
  logic                    pop;

  issue_state_t state, state_next;

  always_comb begin
    word = '0;
    if (in_fmt == FMT_COST) begin
      word = {in_op, in_cost_type};
    end else begin
      word = {in_op, in_act_type, in_dense_type};
    end
  end

  assign push = in_valid && in_ready && !flush;

  code_fifo #(
    .width (entry_w),
    .depth (depth)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data ({word, in_repeat}),
    .pop       (pop),
    .head_data (head_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign head_word   = head_data[entry_w-1:repeat_width];
  assign head_repeat = head_data[repeat_width-1:0];

  assign in_ready  = !fifo_full;
  assign count     = fifo_count;
  assign out_valid = !fifo_empty;
  assign code      = out_valid ? head_word : '0;
  assign last_beat = (rep_cnt == head_repeat);
  assign out_last  = out_valid && last_beat;
  assign beat      = out_valid && out_ready;
  assign pop       = beat && last_beat && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (push) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          state_next = ST_IDLE;
        end else if (pop && (fifo_count == cnt_w'(1)) && !push) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // rep_cnt counts beats already issued for the head; it returns to zero
  // whenever the head is popped so the next entry starts fresh.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt <= '0;
    end else if (flush || state == ST_IDLE) begin
      rep_cnt <= '0;
    end else if (beat) begin
      if (last_beat) begin
        rep_cnt <= '0;
      end else begin
        rep_cnt <= rep_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_code_issue.sv
module tb_code_issue;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        in_fmt;
  logic [3:0]  in_op;
  logic [3:0]  in_act_type;
  logic [3:0]  in_dense_type;
  logic [7:0]  in_cost_type;
  logic [3:0]  in_repeat;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] code;
  logic        out_last;
  logic [2:0]  count;

  int errors = 0;
  int checks = 0;

  code_issue #(.depth(4), .repeat_width(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_fmt        (in_fmt),
    .in_op         (in_op),
    .in_act_type   (in_act_type),
    .in_dense_type (in_dense_type),
    .in_cost_type  (in_cost_type),
    .in_repeat     (in_repeat),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .code          (code),
    .out_last      (out_last),
    .count         (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_split(input logic [3:0] op, input logic [3:0] act,
                           input logic [3:0] dense, input logic [3:0] rep);
    in_valid      = 1'b1;
    in_fmt        = 1'b0;
    in_op         = op;
    in_act_type   = act;
    in_dense_type = dense;
    in_cost_type  = 8'hFF;
    in_repeat     = rep;
  endtask

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (code !== 12'h000) begin errors++; $display("FAIL reset_code got=%h exp=000", code); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%0b exp=0", out_last); end
  endtask

  task automatic test_split();
    out_ready = 1'b1;
    set_split(4'h3, 4'h2, 4'h5, 4'h0);
    step();
    in_valid = 1'b0;
    checks++; if (code !== 12'h325) begin errors++; $display("FAIL split_code got=%h exp=325", code); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL split_valid got=%0b exp=1", out_valid); end
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL split_last got=%0b exp=1", out_last); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL split_count got=%0d exp=1", count); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL split_drain_valid got=%0b exp=0", out_valid); end
    checks++; if (code !== 12'h000) begin errors++; $display("FAIL split_drain_code got=%h exp=000", code); end
  endtask

  task automatic test_cost();
    out_ready     = 1'b0;
    in_valid      = 1'b1;
    in_fmt        = 1'b1;
    in_op         = 4'h9;
    in_act_type   = 4'h0;
    in_dense_type = 4'h0;
    in_cost_type  = 8'hA7;
    in_repeat     = 4'h0;
    step();
    in_valid = 1'b0;
    checks++; if (code !== 12'h9A7) begin errors++; $display("FAIL cost_code got=%h exp=9A7", code); end
    checks++; if (code[7:4] !== 4'hA) begin errors++; $display("FAIL cost_act got=%h exp=A", code[7:4]); end
    checks++; if (code[3:0] !== 4'h7) begin errors++; $display("FAIL cost_dense got=%h exp=7", code[3:0]); end
    step();
    checks++; if (code !== 12'h9A7) begin errors++; $display("FAIL cost_hold got=%h exp=9A7", code); end
    out_ready = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cost_drain got=%0b exp=0", out_valid); end
  endtask

  task automatic test_repeat();
    logic [11:0] exp_code [4];
    logic        exp_last [4];
    exp_code = '{12'h111, 12'h111, 12'h111, 12'h200};
    exp_last = '{1'b0, 1'b0, 1'b1, 1'b1};
    out_ready = 1'b0;
    set_split(4'h1, 4'h1, 4'h1, 4'h2);
    step();
    set_split(4'h2, 4'h0, 4'h0, 4'h0);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (code !== exp_code[i]) begin errors++; $display("FAIL repeat_code beat=%0d got=%h exp=%h", i, code, exp_code[i]); end
      checks++; if (out_last !== exp_last[i]) begin errors++; $display("FAIL repeat_last beat=%0d got=%0b exp=%0b", i, out_last, exp_last[i]); end
      step();
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL repeat_end got=%0b exp=0", out_valid); end
  endtask

  task automatic test_full();
    logic [11:0] exp_code [4];
    exp_code = '{12'h412, 12'h534, 12'h656, 12'h778};
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_split(exp_code[i][11:8], exp_code[i][7:4], exp_code[i][3:0], 4'h0);
      step();
    end
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_count got=%0d exp=4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready got=%0b exp=0", in_ready); end
    set_split(4'hF, 4'hF, 4'hF, 4'h0);
    step();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL full_reject got=%0d exp=4", count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (code !== exp_code[i]) begin errors++; $display("FAIL full_order idx=%0d got=%h exp=%h", i, code, exp_code[i]); end
      step();
      if (i == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_ready_rise got=%0b exp=1", in_ready); end
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_count_pop got=%0d exp=3", count); end
      end
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL full_drained got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b1;
    set_split(4'hC, 4'h1, 4'h2, 4'h5);
    step();
    in_valid = 1'b0;
    checks++; if (code !== 12'hC12) begin errors++; $display("FAIL flush_head got=%h exp=C12", code); end
    step();
    step();
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL flush_mid_last got=%0b exp=0", out_last); end
    set_split(4'hD, 4'h3, 4'h4, 4'h0);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%0b exp=1", in_ready); end
    step();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL flush_dropped got=%0d exp=0", count); end
    // A fresh entry after flush must start its repeat count from zero.
    set_split(4'h5, 4'h5, 4'h5, 4'h1);
    out_ready = 1'b0;
    step();
    in_valid = 1'b0;
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL flush_rep_clear got=%0b exp=0", out_last); end
    out_ready = 1'b1;
    step();
    checks++; if (out_last !== 1'b1) begin errors++; $display("FAIL flush_rep_second got=%0b exp=1", out_last); end
    step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_rep_done got=%0b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    set_split(4'h6, 4'h1, 4'h1, 4'h0);
    step();
    set_split(4'h7, 4'h2, 4'h2, 4'h0);
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    checks++; if (code !== 12'h722) begin errors++; $display("FAIL areset_pre_code got=%h exp=722", code); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_valid got=%0b exp=0", out_valid); end
    checks++; if (code !== 12'h000) begin errors++; $display("FAIL areset_code got=%h exp=000", code); end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL areset_count got=%0d exp=0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL areset_ready got=%0b exp=1", in_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++; if (code !== 12'h000) begin errors++; $display("FAIL areset_release_code got=%h exp=000", code); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_release_valid got=%0b exp=0", out_valid); end
  endtask

  initial begin
    rst_n         = 1'b0;
    in_valid      = 1'b0;
    in_fmt        = 1'b0;
    in_op         = '0;
    in_act_type   = '0;
    in_dense_type = '0;
    in_cost_type  = '0;
    in_repeat     = '0;
    flush         = 1'b0;
    out_ready     = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    test_split();
    test_cost();
    test_repeat();
    test_full();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
